// File: rtl/hdspsr_trim_pkg.sv
// Shared types for the hdspsr trim distributor: trim field layout and FSM states.
package hdspsr_trim_pkg;

  localparam int TRIM_W = 19;

  // Field order matches the TDR override packing, MSB first.
  typedef struct packed {
    logic [2:0] wa;
    logic [1:0] ra;
    logic [1:0] wmce;
    logic [1:0] wpulse;
    logic       mce;
    logic       shutoff;
    logic       wa_disable;
    logic       stbyp;
    logic [3:0] rmce;
    logic [1:0] sbc;
  } hdspsr_trim_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_UPDATE
  } trim_state_e;

endpackage

// File: rtl/hdspsr_trim_rot_shreg.sv
// TRIM_W-bit circular right-rotating shift register with parallel load.
module hdspsr_trim_rot_shreg
  import hdspsr_trim_pkg::*;
(
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              load,
  input  logic [TRIM_W-1:0] load_val,
  input  logic              rot,
  output logic [TRIM_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (rot) begin
      q <= {q[0], q[TRIM_W-1:1]};
    end
  end

endmodule

// File: rtl/hdspsr_trim_distributor.sv
// Resolves fuse/override trim and broadcasts it LSB-first down the hdspsr trim chain.
// Optional tail readback compare: define HDSPSR_TRIM_READBACK_CHK_EN.
module hdspsr_trim_distributor
  import hdspsr_trim_pkg::*;
#(
  parameter int NUM_ARRAYS = 4
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              fuse_valid,
  input  logic [TRIM_W-1:0] fuse_trim,
  input  logic              trim_ovrd_en,
  input  logic [TRIM_W-1:0] ovrd_trim,
  input  logic              apply_req,
  output logic              trim_sdo,
  output logic              trim_shift_en,
  output logic              trim_update,
  input  logic              trim_sdi,
  output logic              busy,
  output logic              done,
  output logic [TRIM_W-1:0] applied_trim,
  output logic              trim_err
);

  localparam int CHAIN_LEN = NUM_ARRAYS * TRIM_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  trim_state_e       state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              applied_valid;
  hdspsr_trim_t      resolved;
  logic              src_ok;
  logic              trigger;
  logic              load;
  logic              rot;
  logic              next_sdo;
  logic [TRIM_W-1:0] shreg_q;

  assign resolved = trim_ovrd_en ? hdspsr_trim_t'(ovrd_trim) : hdspsr_trim_t'(fuse_trim);
  assign src_ok   = fuse_valid | trim_ovrd_en;
  assign trigger  = src_ok & (~applied_valid | (resolved != hdspsr_trim_t'(applied_trim)) | apply_req);

  hdspsr_trim_rot_shreg u_data_shreg (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .load        (load),
    .load_val    (resolved),
    .rot         (rot),
    .q           (shreg_q)
  );

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) state <= ST_IDLE;
    else              state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    rot        = 1'b0;
    next_sdo   = 1'b0;
    unique case (state)
      ST_IDLE:   if (trigger) next_state = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        rot = 1'b1;
        if (cnt == CNT_LAST) next_state = ST_UPDATE;
      end
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    // Registered sdo must already hold the bit the shift register will present next cycle.
    if (next_state == ST_SHIFT) next_sdo = load ? resolved[0] : shreg_q[1];
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      cnt           <= '0;
      applied_trim  <= '0;
      applied_valid <= 1'b0;
      trim_sdo      <= 1'b0;
      trim_shift_en <= 1'b0;
      trim_update   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (load)     cnt <= '0;
      else if (rot) cnt <= cnt + 1'b1;
      // After CHAIN_LEN rotations (a multiple of TRIM_W) the register holds the captured word again.
      if (state == ST_UPDATE) begin
        applied_trim  <= shreg_q;
        applied_valid <= 1'b1;
      end
      busy          <= (next_state != ST_IDLE);
      trim_shift_en <= (next_state == ST_SHIFT);
      trim_update   <= (next_state == ST_UPDATE);
      done          <= (state == ST_UPDATE);
      trim_sdo      <= next_sdo;
    end
  end

`ifdef HDSPSR_TRIM_READBACK_CHK_EN
  logic [TRIM_W-1:0] rb_q;
  logic              chk_armed;
  logic              rb_unused_hi;

  // The previous pass's word emerges at the tail in the same order it was sent.
  hdspsr_trim_rot_shreg u_rb_shreg (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .load        (load),
    .load_val    (applied_trim),
    .rot         (rot),
    .q           (rb_q)
  );

  assign rb_unused_hi = ^rb_q[TRIM_W-1:1];

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      chk_armed <= 1'b0;
      trim_err  <= 1'b0;
    end else begin
      if (load) chk_armed <= applied_valid;
      if (rot && chk_armed && (trim_sdi != rb_q[0])) trim_err <= 1'b1;
    end
  end
`else
  logic sdi_unused;

  assign sdi_unused = trim_sdi;
  assign trim_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hdspsr_trim_distributor.sv
// Scoreboard bench: stimulus predicts committed words, a monitor checks serial stream and commit.
module tb_hdspsr_trim_distributor;
  import hdspsr_trim_pkg::*;

  localparam int NUM_ARRAYS = 4;
  localparam int CHAIN_LEN  = NUM_ARRAYS * TRIM_W;
  localparam int BUDGET     = 400;

  logic              ijtag_tck    = 1'b0;
  logic              ijtag_reset  = 1'b0;
  logic              fuse_valid   = 1'b0;
  logic [TRIM_W-1:0] fuse_trim    = '0;
  logic              trim_ovrd_en = 1'b0;
  logic [TRIM_W-1:0] ovrd_trim    = '0;
  logic              apply_req    = 1'b0;
  logic              trim_sdo, trim_shift_en, trim_update, trim_sdi;
  logic              busy, done, trim_err;
  logic [TRIM_W-1:0] applied_trim;

  int checks = 0;
  int errors = 0;

  logic [TRIM_W-1:0] exp_q[$];
  logic [TRIM_W-1:0] model_applied = '0;
  bit                model_valid   = 1'b0;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 flip  = 1'b0;

  bit                mon_pend = 1'b0;
  logic [TRIM_W-1:0] mon_word;
  logic              mon_bits[$];
  int                mon_bad;

  hdspsr_trim_distributor #(.NUM_ARRAYS(NUM_ARRAYS)) dut (
    .ijtag_tck     (ijtag_tck),
    .ijtag_reset   (ijtag_reset),
    .fuse_valid    (fuse_valid),
    .fuse_trim     (fuse_trim),
    .trim_ovrd_en  (trim_ovrd_en),
    .ovrd_trim     (ovrd_trim),
    .apply_req     (apply_req),
    .trim_sdo      (trim_sdo),
    .trim_shift_en (trim_shift_en),
    .trim_update   (trim_update),
    .trim_sdi      (trim_sdi),
    .busy          (busy),
    .done          (done),
    .applied_trim  (applied_trim),
    .trim_err      (trim_err)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // Downstream daisy chain of trim registers; the tail returns what was shifted in CHAIN_LEN bits ago.
  assign trim_sdi = chain[CHAIN_LEN-1] ^ flip;
  always @(posedge ijtag_tck)
    if (trim_shift_en) chain <= {chain[CHAIN_LEN-2:0], trim_sdo};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy,          0);
    check({tag, "_shift_en"}, trim_shift_en, 0);
    check({tag, "_update"},   trim_update,   0);
    check({tag, "_done"},     done,          0);
    check({tag, "_sdo"},      trim_sdo,      0);
    check({tag, "_applied"},  applied_trim,  0);
    check({tag, "_err"},      trim_err,      0);
  endtask

  function automatic logic [TRIM_W-1:0] ref_resolved();
    return trim_ovrd_en ? ovrd_trim : fuse_trim;
  endfunction

  // Reference model: a pass happens iff a source is valid and the word is new, never committed, or forced.
  task automatic predict(input bit apply, output bit fired);
    fired = 1'b0;
    if ((fuse_valid || trim_ovrd_en) &&
        (!model_valid || ref_resolved() != model_applied || apply)) begin
      exp_q.push_back(ref_resolved());
      model_applied = ref_resolved();
      model_valid   = 1'b1;
      fired         = 1'b1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 1;
    @(negedge ijtag_tck);
    while (done !== 1'b1 && n < BUDGET) begin
      @(negedge ijtag_tck);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected done=1", done, n);
    end
  endtask

  task automatic step(input bit apply);
    bit fired;
    apply_req = apply;
    predict(apply, fired);
    @(negedge ijtag_tck);
    apply_req = 1'b0;
    if (fired) begin
      check("busy_after_trigger", busy, 1);
      wait_done();
    end else begin
      repeat (3) begin
        check("idle_no_trigger", busy, 0);
        @(negedge ijtag_tck);
      end
    end
  endtask

  // Monitor: collects the serial stream and checks it, the commit and done against the scoreboard.
  always @(negedge ijtag_tck) begin
    if (!ijtag_reset) begin
      mon_bits.delete();
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        check("done_after_update", done, 1);
        check("applied_trim", applied_trim, mon_word);
        mon_pend = 1'b0;
      end else if (done) begin
        check("spurious_done", done, 0);
      end
      if (trim_shift_en) mon_bits.push_back(trim_sdo);
      if (trim_update) begin
        check("update_vs_shift_en", trim_shift_en, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got trim_update=1 expected no pass pending");
        end else begin
          mon_word = exp_q.pop_front();
          check("stream_len", mon_bits.size(), CHAIN_LEN);
          mon_bad = 0;
          foreach (mon_bits[i])
            if (mon_bits[i] !== mon_word[i % TRIM_W]) mon_bad++;
          check("stream_bits_bad", mon_bad, 0);
          mon_pend = 1'b1;
        end
        mon_bits.delete();
      end
    end
  end

  initial begin
    int n;
    bit fired;

    repeat (2) @(negedge ijtag_tck);
    check_all_zero("reset");
    ijtag_reset = 1'b1;
    repeat (3) begin
      @(negedge ijtag_tck);
      check("no_source_idle", busy, 0);
    end

    // First pass from fuse, with exact timing.
    fuse_valid = 1'b1;
    fuse_trim  = 19'h2A5F3;
    predict(1'b0, fired);
    n = 0;
    do begin
      @(negedge ijtag_tck);
      n++;
      if (n == 1) begin
        check("t1_load_busy", busy, 1);
        check("t1_load_no_shift", trim_shift_en, 0);
      end
      if (n == 2) check("t1_first_shift", trim_shift_en, 1);
    end while (trim_update !== 1'b1 && n < BUDGET);
    check("t1_update_cycle", n, CHAIN_LEN + 2);
    @(negedge ijtag_tck);
    check("t1_done", done, 1);
    repeat (3) @(negedge ijtag_tck);

    // Override and back to fuse.
    trim_ovrd_en = 1'b1;
    ovrd_trim    = 19'h00011;
    step(1'b0);
    trim_ovrd_en = 1'b0;
    step(1'b0);

    // Override word changes mid-pass: old word completes, new pass follows back-to-back.
    trim_ovrd_en = 1'b1;
    ovrd_trim    = 19'h12345;
    predict(1'b0, fired);
    repeat (12) @(negedge ijtag_tck);
    ovrd_trim = 19'h7FFFF;
    wait_done();
    predict(1'b0, fired);
    @(negedge ijtag_tck);
    check("b2b_busy", busy, 1);
    wait_done();

    // Reset in the middle of SHIFT.
    trim_ovrd_en = 1'b0;
    predict(1'b0, fired);
    repeat (32) @(negedge ijtag_tck);
    ijtag_reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    exp_q.delete();
    model_valid   = 1'b0;
    model_applied = '0;
    repeat (2) begin
      @(negedge ijtag_tck);
      check("rst_hold_no_update", trim_update, 0);
    end
    ijtag_reset = 1'b1;
    predict(1'b0, fired);
    @(negedge ijtag_tck);
    check("rerun_busy", busy, 1);
    wait_done();
    check("first_pass_no_err", trim_err, 0);

    // Forced re-broadcast, then a forced request with no valid source.
    step(1'b1);
    fuse_valid = 1'b0;
    step(1'b1);
    fuse_valid = 1'b1;
    step(1'b0);

    for (int k = 0; k < 10; k++) begin
      fuse_valid   = ($urandom_range(0, 3) != 0);
      trim_ovrd_en = $urandom_range(0, 1) == 1;
      ovrd_trim    = TRIM_W'($urandom);
      if ($urandom_range(0, 2) != 0) fuse_trim = TRIM_W'($urandom);
      step($urandom_range(0, 3) == 0);
    end
    check("random_no_err", trim_err, 0);

    // Corrupt one returned bit during a full pass.
    fuse_valid = 1'b1;
    apply_req  = 1'b1;
    predict(1'b1, fired);
    @(negedge ijtag_tck);
    apply_req = 1'b0;
    repeat (20) @(negedge ijtag_tck);
`ifdef HDSPSR_TRIM_READBACK_CHK_EN
    flip = 1'b1;
    @(negedge ijtag_tck);
    flip = 1'b0;
`endif
    wait_done();
`ifdef HDSPSR_TRIM_READBACK_CHK_EN
    check("readback_err_set", trim_err, 1);
    step(1'b1);
    check("readback_err_sticky", trim_err, 1);
`else
    check("err_tied_low", trim_err, 0);
    step(1'b1);
    check("err_tied_low_again", trim_err, 0);
`endif

    repeat (3) @(negedge ijtag_tck);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d passes outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
